ddrif_hzz: RTL and testbench

- HZZ-side front end of the DDR interface; runs in the accelerator (HZZ) clock domain.
- Accepts one read or write burst request at a time from accelerator masters.
- Serialises each request into a command word plus write beats into the HZZ2UI FIFO.
- Drains the UI2HZZ FIFO into a read-data stream, or consumes the write-acknowledge word, and then retires the request.

---
 rtl/ddrif_pkg.sv | 39 +++
 rtl/ddrif_hzz.sv | 140 ++++++++++++++
 tb/tb_ddrif_hzz.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ddrif_pkg.sv
// Shared definitions for the HZZ-side DDR interface front end.
//   - word/field widths of the HZZ2UI/UI2HZZ FIFOs and command word
//   - command-word field positions and the write-acknowledge word
//   - FSM state encoding
//   - pack_cmd(): builds the command word pushed ahead of each burst
package ddrif_pkg;

    localparam int DDRIF_HZZ_DW = 256;
    localparam int DDRIF_APP_AW = 29;
    localparam int DDRIF_LEN_W  = 8;

    localparam int CMD_WR_BIT  = DDRIF_HZZ_DW - 1;
    localparam int CMD_LEN_MSB = DDRIF_HZZ_DW - 3;

    localparam logic [DDRIF_HZZ_DW-1:0] WR_ACK_WORD = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDAT,
        ST_WACK,
        ST_RDAT
    } ddrif_hzz_state_t;

    // Bit HZZ_DW-2 stays 0; it is reserved in the command word.
    function automatic logic [DDRIF_HZZ_DW-1:0] pack_cmd(
        input logic                    wr,
        input logic [DDRIF_LEN_W-1:0]  len,
        input logic [DDRIF_APP_AW-1:0] addr
    );
        logic [DDRIF_HZZ_DW-1:0] c;
        c                          = '0;
        c[CMD_WR_BIT]              = wr;
        c[CMD_LEN_MSB -: DDRIF_LEN_W] = len;
        c[DDRIF_APP_AW-1:0]        = addr;
        return c;
    endfunction

endpackage

// File: rtl/ddrif_hzz.sv
// HZZ-side front end of the DDR interface (accelerator clock domain).
// Takes one read/write burst request at a time, pushes a command word and
// (for writes) the write beats into the HZZ2UI FIFO, then either streams
// read beats out of the UI2HZZ FIFO or waits for the write-ack word.
// Ports:
//   hzz_clk, hzz_rst_n         clock, async active-low reset
//   req_*                      burst request (valid/ready, wr, addr, len)
//   wdat_*                     write beat stream in (valid/ready)
//   rdat_*                     read beat stream out (valid/ready, last)
//   wr_done                    one-cycle pulse when a write is acknowledged
//   busy                       transaction in flight
//   h2u_*                      HZZ2UI FIFO write side
//   u2h_*                      UI2HZZ FIFO read side (first-word-fall-through)
module ddrif_hzz
    import ddrif_pkg::*;
#(
    parameter int HZZ_DW = DDRIF_HZZ_DW,
    parameter int APP_AW = DDRIF_APP_AW,
    parameter int LEN_W  = DDRIF_LEN_W
) (
    input  logic              hzz_clk,
    input  logic              hzz_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [APP_AW-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [HZZ_DW-1:0] wdat_data,
    output logic              rdat_valid,
    input  logic              rdat_ready,
    output logic [HZZ_DW-1:0] rdat_data,
    output logic              rdat_last,
    output logic              wr_done,
    output logic              busy,
    output logic [HZZ_DW-1:0] h2u_wdata,
    output logic              h2u_wen,
    input  logic              h2u_wfull,
    input  logic [HZZ_DW-1:0] u2h_rdata,
    output logic              u2h_ren,
    input  logic              u2h_rempty
);

    ddrif_hzz_state_t  state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    // Holds req_ready low while in reset even though the state is IDLE.
    logic              init_q;

    always_ff @(posedge hzz_clk or negedge hzz_rst_n) begin
        if (!hzz_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        done_d     = 1'b0;
        req_ready  = 1'b0;
        wdat_ready = 1'b0;
        rdat_valid = 1'b0;
        rdat_data  = '0;
        rdat_last  = 1'b0;
        h2u_wdata  = '0;
        h2u_wen    = 1'b0;
        u2h_ren    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = init_q;
                if (req_valid && init_q) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = req_len;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                h2u_wdata = pack_cmd(wr_q, len_q, addr_q);
                h2u_wen   = !h2u_wfull;
                if (!h2u_wfull) state_d = wr_q ? ST_WDAT : ST_RDAT;
            end
            ST_WDAT: begin
                wdat_ready = !h2u_wfull;
                h2u_wen    = wdat_valid && !h2u_wfull;
                h2u_wdata  = wdat_data;
                if (h2u_wen) begin
                    if (cnt_q == '0) state_d = ST_WACK;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_WACK: begin
                // Anything other than the ack word is popped and dropped.
                u2h_ren = !u2h_rempty;
                if (u2h_ren && (u2h_rdata == WR_ACK_WORD)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RDAT: begin
                rdat_valid = !u2h_rempty;
                rdat_data  = u2h_rdata;
                rdat_last  = (cnt_q == '0);
                u2h_ren    = rdat_valid && rdat_ready;
                if (u2h_ren) begin
                    if (cnt_q == '0) state_d = ST_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_done = done_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddrif_hzz.sv
module tb_ddrif_hzz;

    logic         hzz_clk = 1'b0;
    logic         hzz_rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [28:0]  req_addr = '0;
    logic [7:0]   req_len = '0;
    logic         wdat_valid = 1'b0, wdat_ready;
    logic [255:0] wdat_data = '0;
    logic         rdat_valid, rdat_ready = 1'b1, rdat_last;
    logic [255:0] rdat_data;
    logic         wr_done, busy;
    logic [255:0] h2u_wdata;
    logic         h2u_wen, h2u_wfull = 1'b0;
    logic [255:0] u2h_rdata = '0;
    logic         u2h_ren, u2h_rempty = 1'b1;

    always #5 hzz_clk = ~hzz_clk;

    ddrif_hzz dut (
        .hzz_clk(hzz_clk), .hzz_rst_n(hzz_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
        .rdat_last(rdat_last), .wr_done(wr_done), .busy(busy),
        .h2u_wdata(h2u_wdata), .h2u_wen(h2u_wen), .h2u_wfull(h2u_wfull),
        .u2h_rdata(u2h_rdata), .u2h_ren(u2h_ren), .u2h_rempty(u2h_rempty)
    );

    int errs = 0, checks = 0;
    logic [255:0] h2u_exp[$];   // expected HZZ2UI pushes
    logic [256:0] r_exp[$];     // expected {last, data} read beats
    logic [255:0] u2h_q[$];     // UI2HZZ FIFO model contents
    logic [255:0] wq[$];        // write beats offered on wdat
    int  exp_wrdone = 0;
    int  wdat_hs = 0;
    bit  wfull_rnd = 0, gap_rnd = 0, rrdy_rnd = 0;
    bit  busy_chk = 0;

    task automatic chk(input string nm, input logic [256:0] a, input logic [256:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    function automatic logic [255:0] ecmd(input bit wr, input int len, input int addr);
        logic [255:0] c;
        c = (256'(wr) << 255) | (256'(len) << 246) | 256'(addr);
        return c;
    endfunction

    // FIFO / stream models: sample handshakes on the edge, update #1 later.
    always @(posedge hzz_clk) begin
        if (u2h_ren && !u2h_rempty && u2h_q.size() != 0) void'(u2h_q.pop_front());
        if (wdat_valid && wdat_ready && wq.size() != 0) begin
            void'(wq.pop_front());
            wdat_hs++;
        end
        #1;
        h2u_wfull  = wfull_rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
        u2h_rempty = (u2h_q.size() == 0) || (gap_rnd && ($urandom_range(0, 2) == 0));
        u2h_rdata  = (u2h_q.size() != 0) ? u2h_q[0] : '0;
        wdat_valid = (wq.size() != 0);
        wdat_data  = (wq.size() != 0) ? wq[0] : '0;
        rdat_ready = rrdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor / scoreboard.
    always @(negedge hzz_clk) begin
        if (hzz_rst_n) begin
            if (h2u_wen) begin
                if (h2u_exp.size() == 0) chk("h2u_extra", {1'b0, h2u_wdata}, 257'd0);
                else                     chk("h2u_word", {1'b0, h2u_wdata}, {1'b0, h2u_exp.pop_front()});
            end
            if (u2h_rempty) chk("ren_while_empty", 257'(u2h_ren), 257'd0);
            if (h2u_wfull)  chk("wrdy_while_full", 257'(wdat_ready), 257'd0);
            if (busy_chk)   chk("busy_after_last", 257'(busy), 257'd0);
            busy_chk = rdat_valid && rdat_ready && rdat_last;
            if (rdat_valid && rdat_ready) begin
                if (r_exp.size() == 0) chk("rdat_extra", {rdat_last, rdat_data}, 257'd0);
                else                   chk("rdat_beat", {rdat_last, rdat_data}, r_exp.pop_front());
            end
            if (wr_done) begin
                chk("wr_done_expected", 257'(exp_wrdone > 0), 257'd1);
                chk("busy_at_wr_done", 257'(busy), 257'd0);
                if (exp_wrdone > 0) exp_wrdone--;
            end
        end
    end

    task automatic issue(input bit wr, input int addr, input int len);
        bit got = 0;
        @(posedge hzz_clk); #1;
        req_valid = 1'b1; req_wr = wr; req_addr = 29'(addr); req_len = 8'(len);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge hzz_clk);
            if (req_ready) got = 1;
        end
        if (!got) chk("req_accept_timeout", 257'd0, 257'd1);
        @(posedge hzz_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge hzz_clk);
            if (!busy && h2u_exp.size() == 0 && r_exp.size() == 0 && exp_wrdone == 0) ok = 1;
        end
        chk(nm, 257'(ok), 257'd1);
    endtask

    task automatic do_write(input int addr, input int len, input logic [255:0] base, input bit ack);
        h2u_exp.push_back(ecmd(1, len, addr));
        for (int i = 0; i <= len; i++) begin
            h2u_exp.push_back(base + 256'(i));
            wq.push_back(base + 256'(i));
        end
        if (ack) begin
            exp_wrdone++;
            u2h_q.push_back('1);
        end
        issue(1, addr, len);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_req_ready"}, 257'(req_ready), 257'd0);
        chk({nm, "_busy"}, 257'(busy), 257'd0);
        chk({nm, "_h2u_wen"}, 257'(h2u_wen), 257'd0);
        chk({nm, "_h2u_wdata"}, {1'b0, h2u_wdata}, 257'd0);
        chk({nm, "_u2h_ren"}, 257'(u2h_ren), 257'd0);
        chk({nm, "_rdat"}, {rdat_valid, rdat_last, wdat_ready, wr_done}, 257'd0);
        chk({nm, "_rdat_data"}, {1'b0, rdat_data}, 257'd0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge hzz_clk); hzz_rst_n = 1'b1;
        @(negedge hzz_clk); @(negedge hzz_clk);
        chk("req_ready_after_reset", 257'(req_ready), 257'd1);

        // 1: write len=3, addr 0x100, then ack
        do_write('h100, 3, 256'hD000, 1);
        wait_idle("wr_len3_done");

        // 2: read len=0, addr 0x20
        h2u_exp.push_back(ecmd(0, 0, 'h20));
        r_exp.push_back({1'b1, 256'hABCD});
        issue(0, 'h20, 0);
        u2h_q.push_back(256'hABCD);
        wait_idle("rd_len0_done");

        // 3: read len=7 with ready toggling and empty gaps
        rrdy_rnd = 1; gap_rnd = 1;
        h2u_exp.push_back(ecmd(0, 7, 'h1ABCDEF));
        for (int i = 0; i < 8; i++) begin
            r_exp.push_back({(i == 7), 256'hE000 + 256'(i)});
            u2h_q.push_back(256'hE000 + 256'(i));
        end
        issue(0, 'h1ABCDEF, 7);
        wait_idle("rd_len7_done");
        rrdy_rnd = 0; gap_rnd = 0;

        // 4: write len=255 with random FIFO-full back-pressure
        wfull_rnd = 1;
        do_write('h1FFFFFFF, 255, 256'h5A00_0000, 1);
        wait_idle("wr_len255_done");
        wfull_rnd = 0;

        // 5: junk word in WACK is discarded, ack follows
        do_write('h44, 0, 256'h77, 0);
        u2h_q.push_back(256'h1234);
        repeat (8) @(negedge hzz_clk);
        chk("busy_in_wack", 257'(busy), 257'd1);
        chk("junk_consumed", 257'(u2h_q.size()), 257'd0);
        exp_wrdone++;
        u2h_q.push_back('1);
        wait_idle("wack_junk_done");

        // 6: reset in the middle of a 4-beat write
        wdat_hs = 0;
        do_write('h300, 3, 256'hF000, 0);
        for (int i = 0; i < 200 && wdat_hs < 2; i++) @(negedge hzz_clk);
        chk("two_beats_sent", 257'(wdat_hs), 257'd2);
        #2 hzz_rst_n = 1'b0;
        #1 check_all_zero("midburst_reset");
        h2u_exp.delete(); wq.delete(); u2h_q.delete();
        @(negedge hzz_clk); hzz_rst_n = 1'b1;
        @(negedge hzz_clk); @(negedge hzz_clk);
        chk("req_ready_after_abort", 257'(req_ready), 257'd1);
        h2u_exp.push_back(ecmd(0, 1, 'h55));
        r_exp.push_back({1'b0, 256'hC1});
        r_exp.push_back({1'b1, 256'hC2});
        issue(0, 'h55, 1);
        u2h_q.push_back(256'hC1);
        u2h_q.push_back(256'hC2);
        wait_idle("rd_after_reset_done");

        repeat (3) @(negedge hzz_clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
